pcd_miller_encoder: RTL and testbench

- Reader-side (PCD) stimulus stage directly upstream of the smartcard's `miller_in` pin.
- Takes a byte stream from a host, test harness or on-board reader-emulation logic.
- Emits an ISO14443-A modified-Miller pause waveform: SOF, LSB-first data, odd parity per byte, EOF, then enforced inter-frame gap.
- Used in the FPGA loop-back build and as the bench driver for the ISO14443 front-end.

---
 rtl/pcd_miller_encoder.sv | 185 ++++++++++++++++++
 tb/tb_pcd_miller_encoder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcd_miller_encoder.sv
// ISO14443-A reader-side modified-Miller encoder: SOF, LSB-first data with odd
// parity, EOF and a guaranteed inter-frame gap, fed through a one-deep holding register.
module pcd_miller_encoder #(
    parameter int BIT_CYCLES   = 128,
    parameter int PAUSE_CYCLES = 32,
    parameter int GAP_BITS     = 8
) (
    input  logic       clk_sc,
    input  logic       resetn,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_last,
    input  logic       short_frame,
    output logic       miller_out,
    output logic       busy,
    output logic       underrun,
    output logic       frame_done
);

    localparam int CW   = $clog2(BIT_CYCLES);
    localparam int HALF = BIT_CYCLES / 2;
    localparam int BMAX = (GAP_BITS > 8) ? GAP_BITS : 8;
    localparam int BW   = $clog2(BMAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SOF, DATA, PARITY, EOF0, EOF1, GAP} state_t;
    typedef enum logic [1:0] {SYM_NONE, SYM_Z, SYM_X, SYM_Y} sym_t;

    // Handshake: a byte moves into the holding register on any clk_sc edge where
    // s_valid & s_ready; s_ready is simply "holding register empty".
    state_t        state, state_n;
    sym_t          sym, sym_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [BW-1:0] bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          short_q, short_n, last_q, last_n, par_q, par_n;
    logic [7:0]    hold_data;
    logic          hold_last, hold_short, hold_full;
    logic          load, accept, start_frame, cnt_last, bit_end;

    function automatic sym_t next_sym(input logic b, input sym_t prev);
        if (b)                return SYM_X;
        else if (prev == SYM_X) return SYM_Y;
        else                  return SYM_Z;
    endfunction

    function automatic logic pause_at(input sym_t s, input logic [CW-1:0] c);
        return (s == SYM_Z && int'(c) < PAUSE_CYCLES) ||
               (s == SYM_X && int'(c) >= HALF && int'(c) < HALF + PAUSE_CYCLES);
    endfunction

    assign s_ready  = ~hold_full;
    assign accept   = s_valid & s_ready;
    assign busy     = (state != IDLE);
    assign cnt_last = (cnt == CNT_LAST);
    assign bit_end  = (bit_idx == (short_q ? BW'(6) : BW'(7)));

    always_comb begin
        state_n     = state;
        sym_n       = sym;
        cnt_n       = cnt_last ? '0 : cnt + 1'b1;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        short_n     = short_q;
        last_n      = last_q;
        par_n       = par_q;
        load        = 1'b0;
        start_frame = 1'b0;
        underrun    = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (hold_full) start_frame = 1'b1;
            end
            SOF: if (cnt_last) begin
                state_n = DATA;
                sym_n   = next_sym(shreg[0], sym);
            end
            DATA: if (cnt_last) begin
                if (bit_end && short_q) begin
                    state_n = EOF0;
                    sym_n   = next_sym(1'b0, sym);
                end else if (bit_end) begin
                    state_n = PARITY;
                    sym_n   = next_sym(par_q, sym);
                end else begin
                    bit_idx_n = bit_idx + 1'b1;
                    shreg_n   = {1'b0, shreg[7:1]};
                    sym_n     = next_sym(shreg[1], sym);
                end
            end
            PARITY: if (cnt_last) begin
                if (last_q) begin
                    state_n = EOF0;
                    sym_n   = next_sym(1'b0, sym);
                end else if (hold_full) begin
                    // Continuation byte: its short_frame flag is deliberately dropped.
                    load      = 1'b1;
                    state_n   = DATA;
                    bit_idx_n = '0;
                    shreg_n   = hold_data;
                    last_n    = hold_last;
                    short_n   = 1'b0;
                    par_n     = ~^hold_data;
                    sym_n     = next_sym(hold_data[0], sym);
                end else begin
                    underrun = 1'b1;
                    state_n  = EOF0;
                    sym_n    = next_sym(1'b0, sym);
                end
            end
            EOF0: if (cnt_last) begin
                state_n = EOF1;
                sym_n   = SYM_Y;
            end
            EOF1: if (cnt_last) begin
                frame_done = 1'b1;
                state_n    = GAP;
                sym_n      = SYM_NONE;
                bit_idx_n  = '0;
            end
            GAP: if (cnt_last) begin
                // A byte waiting at the end of the gap starts its SOF immediately,
                // so the carrier-only stretch is exactly GAP_BITS bit periods.
                if (bit_idx == BW'(GAP_BITS - 1)) begin
                    if (hold_full) start_frame = 1'b1;
                    else           state_n = IDLE;
                end else begin
                    bit_idx_n = bit_idx + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (start_frame) begin
            load      = 1'b1;
            state_n   = SOF;
            sym_n     = SYM_Z;
            cnt_n     = '0;
            bit_idx_n = '0;
            shreg_n   = hold_data;
            short_n   = hold_short;
            last_n    = hold_last;
            par_n     = ~^hold_data;
        end
    end

    // miller_out is registered from the next-cycle symbol/counter so pause edges
    // line up with the counter values seen by the state register.
    always_ff @(posedge clk_sc or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            sym        <= SYM_NONE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            short_q    <= 1'b0;
            last_q     <= 1'b0;
            par_q      <= 1'b0;
            miller_out <= 1'b1;
            hold_data  <= '0;
            hold_last  <= 1'b0;
            hold_short <= 1'b0;
            hold_full  <= 1'b0;
        end else begin
            state      <= state_n;
            sym        <= sym_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            short_q    <= short_n;
            last_q     <= last_n;
            par_q      <= par_n;
            miller_out <= ~pause_at(sym_n, cnt_n);
            if (accept) begin
                hold_data  <= s_data;
                hold_last  <= s_last;
                hold_short <= short_frame;
            end
            hold_full <= accept | (hold_full & ~load);
        end
    end

endmodule

// File: tb/tb_pcd_miller_encoder.sv
// Bench for pcd_miller_encoder: drives byte frames and compares the captured
// miller_out waveform against a symbol-level model of the Miller coding rules.
module tb_pcd_miller_encoder;

    localparam int BC = 16;
    localparam int PC = 4;
    localparam int GB = 2;

    logic       clk_sc = 1'b0;
    logic       resetn = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;
    logic       short_frame = 1'b0;
    logic       s_ready, miller_out, busy, underrun, frame_done;

    pcd_miller_encoder #(.BIT_CYCLES(BC), .PAUSE_CYCLES(PC), .GAP_BITS(GB)) dut (
        .clk_sc(clk_sc), .resetn(resetn), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .short_frame(short_frame),
        .miller_out(miller_out), .busy(busy), .underrun(underrun), .frame_done(frame_done)
    );

    always #5 clk_sc = ~clk_sc;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [0:0] exp_q[$];
    logic [0:0] wave_q[$];
    int         done_idx_q[$];
    int         done_cnt, ur_cnt, ur_idx;
    bit         cap_en = 1'b0, cap_started, saw_not_ready, saw_recover;
    logic [7:0] tx_bytes[$];
    bit         tx_short, tx_last;

    // One clock cycle; samples outputs on the falling edge.
    task automatic tick();
        @(negedge clk_sc);
        if (cap_en) begin
            if (!cap_started && miller_out === 1'b0) cap_started = 1'b1;
            if (cap_started) begin
                wave_q.push_back(miller_out);
                if (frame_done === 1'b1) done_idx_q.push_back(wave_q.size() - 1);
                if (underrun === 1'b1) ur_idx = wave_q.size() - 1;
                if (s_ready === 1'b0) saw_not_ready = 1'b1;
                else if (saw_not_ready) saw_recover = 1'b1;
            end
            if (frame_done === 1'b1) done_cnt++;
            if (underrun === 1'b1) ur_cnt++;
        end
    endtask

    task automatic start_capture();
        wave_q.delete();
        done_idx_q.delete();
        done_cnt = 0; ur_cnt = 0; ur_idx = -1;
        cap_started = 1'b0; saw_not_ready = 1'b0; saw_recover = 1'b0;
        cap_en = 1'b1;
    endtask

    // Offers tx_bytes one after another with s_valid held high between bytes.
    task automatic send_frame();
        int g;
        for (int i = 0; i < tx_bytes.size(); i++) begin
            s_valid     = 1'b1;
            s_data      = tx_bytes[i];
            s_last      = (i == tx_bytes.size() - 1) ? tx_last : 1'b0;
            short_frame = (i == 0) ? tx_short : 1'($urandom_range(0, 1));
            g = 0;
            while (s_ready !== 1'b1 && g < 2000) begin tick(); g++; end
            total_cnt++;
            if (g >= 2000) $display("FAIL accept_byte%0d: s_ready=%b after %0d cycles, required 1", i, s_ready, g);
            else pass_cnt++;
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0; short_frame = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int g = 0;
        while (done_cnt < n && g < 3000) begin tick(); g++; end
        total_cnt++;
        if (done_cnt != n) $display("FAIL frame_done_count: got %0d, required %0d", done_cnt, n);
        else pass_cnt++;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy === 1'b1 && g < 2000) begin tick(); g++; end
    endtask

    // Reference: bits -> Miller symbols (0=Z,1=X,2=Y) -> per-cycle carrier levels.
    task automatic model_frame();
        bit         bits[$];
        int         syms[$];
        int         prev;
        logic [7:0] b;
        if (tx_short) begin
            b = tx_bytes[0];
            for (int k = 0; k < 7; k++) bits.push_back(b[k]);
        end else begin
            for (int i = 0; i < tx_bytes.size(); i++) begin
                b = tx_bytes[i];
                for (int k = 0; k < 8; k++) bits.push_back(b[k]);
                bits.push_back(($countones(b) % 2) == 0);
            end
        end
        syms.push_back(0);
        prev = 0;
        for (int i = 0; i < bits.size(); i++) begin
            prev = bits[i] ? 1 : ((prev == 1) ? 2 : 0);
            syms.push_back(prev);
        end
        syms.push_back((prev == 1) ? 2 : 0);
        syms.push_back(2);
        for (int i = 0; i < syms.size(); i++)
            for (int c = 0; c < BC; c++)
                exp_q.push_back(!((syms[i] == 0 && c < PC) ||
                                  (syms[i] == 1 && c >= BC / 2 && c < BC / 2 + PC)));
    endtask

    task automatic check_wave(input string name);
        int first = -1;
        for (int k = 0; k < wave_q.size() && k < exp_q.size(); k++)
            if (wave_q[k] !== exp_q[k] && first < 0) first = k;
        total_cnt++;
        if (first >= 0 || wave_q.size() != exp_q.size())
            $display("FAIL wave_%s: got %0d samples (first diff at %0d), required %0d matching samples",
                     name, wave_q.size(), first, exp_q.size());
        else pass_cnt++;
    endtask

    function automatic int sym_at(input int k);
        if (wave_q.size() < (k + 1) * BC) return -1;
        if (wave_q[k * BC] === 1'b0) return 0;
        if (wave_q[k * BC + BC / 2] === 1'b0) return 1;
        return 2;
    endfunction

    task automatic test_reset();
        repeat (3) tick();
        total_cnt++; if (miller_out !== 1'b1) $display("FAIL reset_miller: got %b, required 1", miller_out); else pass_cnt++;
        total_cnt++; if (s_ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", s_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else pass_cnt++;
        total_cnt++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b, required 0", underrun); else pass_cnt++;
        total_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_done: got %b, required 0", frame_done); else pass_cnt++;
        resetn = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_reqa();
        int exp_sym[10] = '{0, 0, 1, 1, 2, 0, 1, 2, 0, 2};
        int bad = 0;
        int n = 0;
        tx_bytes = '{8'h26}; tx_short = 1'b1; tx_last = 1'b1;
        exp_q.delete(); model_frame();
        start_capture(); send_frame(); wait_done(1); cap_en = 1'b0;
        check_wave("reqa");
        for (int k = 0; k < 10; k++) if (sym_at(k) != exp_sym[k]) bad++;
        total_cnt++; if (bad != 0) $display("FAIL reqa_symbols: %0d symbols differ from Z Z X X Y Z X Y Z Y", bad); else pass_cnt++;
        total_cnt++; if (wave_q.size() != 160) $display("FAIL reqa_length: got %0d cycles, required 160", wave_q.size()); else pass_cnt++;
        total_cnt++; if (ur_cnt != 0) $display("FAIL reqa_underrun: got %0d pulses, required 0", ur_cnt); else pass_cnt++;
        tick();
        while (busy === 1'b1 && n < 200) begin n++; tick(); end
        total_cnt++; if (n != GB * BC) $display("FAIL reqa_gap_busy: got %0d cycles, required %0d", n, GB * BC); else pass_cnt++;
    endtask

    task automatic test_two_byte();
        tx_bytes = '{8'h93, 8'h20}; tx_short = 1'b0; tx_last = 1'b1;
        exp_q.delete(); model_frame();
        start_capture(); send_frame(); wait_done(1); cap_en = 1'b0;
        check_wave("two_byte");
        total_cnt++; if (wave_q.size() != 21 * BC) $display("FAIL two_byte_length: got %0d cycles, required %0d", wave_q.size(), 21 * BC); else pass_cnt++;
        total_cnt++; if (sym_at(9) != 1) $display("FAIL parity_93: got symbol %0d, required X (1)", sym_at(9)); else pass_cnt++;
        total_cnt++; if (sym_at(18) == 1 || sym_at(18) < 0) $display("FAIL parity_20: got symbol %0d, required non-X", sym_at(18)); else pass_cnt++;
        total_cnt++; if (ur_cnt != 0) $display("FAIL two_byte_underrun: got %0d pulses, required 0", ur_cnt); else pass_cnt++;
        total_cnt++; if (!(saw_not_ready && saw_recover)) $display("FAIL two_byte_ready: drop=%b recover=%b, required 1 1", saw_not_ready, saw_recover); else pass_cnt++;
        wait_idle();
    endtask

    task automatic test_underrun();
        tx_bytes = '{8'h50}; tx_short = 1'b0; tx_last = 1'b0;
        exp_q.delete(); model_frame();
        start_capture(); send_frame(); wait_done(1); cap_en = 1'b0;
        check_wave("underrun");
        total_cnt++; if (ur_cnt != 1) $display("FAIL underrun_count: got %0d, required 1", ur_cnt); else pass_cnt++;
        total_cnt++; if (ur_idx != 10 * BC - 1) $display("FAIL underrun_time: got cycle %0d, required %0d", ur_idx, 10 * BC - 1); else pass_cnt++;
        total_cnt++;
        if (done_idx_q.size() != 1 || done_idx_q[0] != 12 * BC - 1) $display("FAIL underrun_done_time: got %0d pulses, required one at cycle %0d", done_idx_q.size(), 12 * BC - 1);
        else pass_cnt++;
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int fi = -1;
        int d0 = -1;
        exp_q.delete();
        tx_bytes = '{8'h52}; tx_short = 1'b1; tx_last = 1'b1;
        model_frame();
        for (int k = 0; k < GB * BC; k++) exp_q.push_back(1'b1);
        start_capture(); send_frame(); wait_done(1);
        tx_bytes = '{8'h26};
        model_frame();
        send_frame(); wait_done(2); cap_en = 1'b0;
        check_wave("back_to_back");
        if (done_idx_q.size() > 0) d0 = done_idx_q[0];
        if (d0 >= 0)
            for (int k = d0 + 1; k < wave_q.size(); k++)
                if (wave_q[k] === 1'b0) begin fi = k; break; end
        total_cnt++;
        if (fi < 0 || fi - d0 - 1 != GB * BC) $display("FAIL b2b_gap: got %0d carrier cycles, required %0d", fi - d0 - 1, GB * BC);
        else pass_cnt++;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int g = 0;
        int bad = 0;
        tx_bytes = '{8'h93}; tx_short = 1'b0; tx_last = 1'b1;
        start_capture(); send_frame();
        while (wave_q.size() < 4 * BC + 2 && g < 2000) begin tick(); g++; end
        total_cnt++; if (miller_out !== 1'b0) $display("FAIL mid_pause: got %b at bit 3, required 0", miller_out); else pass_cnt++;
        #2 resetn = 1'b0;
        #1;
        total_cnt++; if (miller_out !== 1'b1) $display("FAIL mid_reset_miller: got %b, required 1", miller_out); else pass_cnt++;
        cap_en = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (miller_out !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1 || underrun !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        total_cnt++; if (bad != 0) $display("FAIL mid_reset_quiet: got %0d active cycles, required 0", bad); else pass_cnt++;
    endtask

    task automatic test_stream();
        tx_bytes.delete();
        for (int i = 0; i < 3; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
        tx_short = 1'b0; tx_last = 1'b1;
        exp_q.delete(); model_frame();
        start_capture(); send_frame(); wait_done(1); cap_en = 1'b0;
        check_wave("stream3");
        total_cnt++; if (ur_cnt != 0) $display("FAIL stream_underrun: got %0d pulses, required 0", ur_cnt); else pass_cnt++;
        wait_idle();
    endtask

    task automatic test_random_frames();
        int nb;
        for (int r = 0; r < 4; r++) begin
            tx_short = ($urandom_range(0, 3) == 0);
            nb = tx_short ? 1 : $urandom_range(1, 3);
            tx_last = 1'b1;
            tx_bytes.delete();
            for (int i = 0; i < nb; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
            exp_q.delete(); model_frame();
            start_capture(); send_frame(); wait_done(1); cap_en = 1'b0;
            check_wave($sformatf("random%0d", r));
            wait_idle();
        end
    endtask

    initial begin
        test_reset();
        test_reqa();
        test_two_byte();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        test_stream();
        test_random_frames();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
